// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Word-addressed memory responder for the multicycle datapath's
//            memory bus. It accepts one read or write request at a time
//            through a valid/ready handshake, inserts WAIT_CYCLES wait
//            states, and returns a one-cycle response pulse carrying read
//            data and an error flag.
// Ports    : clock       - system clock, rising edge
//            reset_l     - asynchronous active-low reset
//            req_valid   - request present
//            req_write   - 1 = write, 0 = read
//            req_addr    - byte address (32 bits)
//            req_wdata   - write data (32 bits)
//            req_ready   - responder can accept a request (state == IDLE)
//            resp_valid  - one-cycle response pulse
//            resp_rdata  - read data, valid while resp_valid = 1
//            resp_err    - access rejected, valid while resp_valid = 1
// Options  : MEM_RESPONDER_ALIGN_CHECK_EN - when defined, a byte address with
//            addr[1:0] != 0 is rejected like an out-of-range access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset_l,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         c_depth     = 1 << ADDR_BITS;
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;
    localparam logic [3:0] c_wait_init = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]           r_state;
    logic [3:0]           r_count;
    logic                 r_write;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_mem [c_depth];

    logic                 w_accept;
    logic                 w_commit;
    logic                 w_c_write;
    logic [31:0]          w_c_addr;
    logic [31:0]          w_c_wdata;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_err;

    assign req_ready = (r_state == c_st_idle);
    assign w_accept  = req_ready && req_valid;

    // The commit edge is the one that enters RESP. With no wait states that
    // is the accept edge itself, so the live request drives the commit.
    assign w_commit  = (w_accept && (WAIT_CYCLES == 0)) ||
                       ((r_state == c_st_wait) && (r_count == 4'd0));

    assign w_c_write = req_ready ? req_write : r_write;
    assign w_c_addr  = req_ready ? req_addr  : r_addr;
    assign w_c_wdata = req_ready ? req_wdata : r_wdata;
    assign w_idx     = w_c_addr[ADDR_BITS+1:2];

    always_comb begin
        // Any address bit above the storage window makes the access illegal.
        w_err = (w_c_addr >> (ADDR_BITS + 2)) != 32'd0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        if (w_c_addr[1:0] != 2'b00) begin
            w_err = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            r_state    <= c_st_idle;
            r_count    <= 4'd0;
            r_write    <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            // The pulse follows the single cycle spent in RESP, so a reset
            // landing in RESP suppresses the response.
            resp_valid <= (r_state == c_st_resp);

            // Response data/error are captured at the commit edge and then
            // hold until the next commit.
            if (w_commit) begin
                resp_err   <= w_err;
                resp_rdata <= (w_err || w_c_write) ? 32'd0 : r_mem[w_idx];
            end

            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= c_st_resp;
                        end else begin
                            r_state <= c_st_wait;
                            r_count <= c_wait_init;
                        end
                    end
                end
                c_st_wait: begin
                    if (r_count == 4'd0) begin
                        r_state <= c_st_resp;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                c_st_resp: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Storage is deliberately not reset. A write only lands on its commit
    // edge, so a reset before that edge abandons it.
    always_ff @(posedge clock) begin
        if (w_commit && w_c_write && !w_err) begin
            r_mem[w_idx] <= w_c_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Self-checking bench for mem_responder. Three instances with
//            WAIT_CYCLES = 0, 1 and 3 share clock and reset. A timeline model
//            (accept edge, commit edge, response edge, word array) predicts
//            every output each cycle; directed sequences pin it with literals.
// Options  : MEM_RESPONDER_ALIGN_CHECK_EN selects the aligned-access model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int c_n = 3;

    logic        clock   = 1'b0;
    logic        reset_l = 1'b0;
    logic        req_valid  [c_n];
    logic        req_write  [c_n];
    logic [31:0] req_addr   [c_n];
    logic [31:0] req_wdata  [c_n];
    logic        req_ready  [c_n];
    logic        resp_valid [c_n];
    logic [31:0] resp_rdata [c_n];
    logic        resp_err   [c_n];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    for (genvar g = 0; g < c_n; g++) begin : g_dut
        mem_responder #(
            .ADDR_BITS  (8),
            .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clock     (clock),
            .reset_l   (reset_l),
            .req_valid (req_valid[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_ready (req_ready[g]),
            .resp_valid(resp_valid[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[dut%0d] @%0t: got %h, expected %h", nm, k, $time, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    int unsigned edge_n = 0;
    bit          pend      [c_n];
    int unsigned commit_e  [c_n];
    int unsigned due_e     [c_n];
    bit          p_wr      [c_n];
    logic [31:0] p_addr    [c_n];
    logic [31:0] p_wdata   [c_n];
    bit          rv_e      [c_n];
    logic [31:0] cur_rd    [c_n];
    bit          cur_err   [c_n];
    bit          cur_known [c_n];
    logic [31:0] mmem      [c_n][256];
    bit          mknown    [c_n][256];

    function automatic bit addr_err(input logic [31:0] a);
        bit e;
        e = (a >= 32'h400);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic model_commit(input int k);
        int idx;
        idx = int'(p_addr[k][9:2]);
        if (addr_err(p_addr[k])) begin
            cur_rd[k] = 32'd0; cur_err[k] = 1'b1; cur_known[k] = 1'b1;
        end else if (p_wr[k]) begin
            mmem[k][idx] = p_wdata[k]; mknown[k][idx] = 1'b1;
            cur_rd[k] = 32'd0; cur_err[k] = 1'b0; cur_known[k] = 1'b1;
        end else begin
            cur_rd[k] = mmem[k][idx]; cur_err[k] = 1'b0; cur_known[k] = mknown[k][idx];
        end
    endtask

    initial begin
        bit rb;
        forever begin
            @(posedge clock);
            edge_n++;
            for (int k = 0; k < c_n; k++) begin
                if (!reset_l) begin
                    pend[k] = 1'b0; rv_e[k] = 1'b0;
                    cur_rd[k] = 32'd0; cur_err[k] = 1'b0; cur_known[k] = 1'b1;
                end else begin
                    rb = !pend[k];
                    if (pend[k] && edge_n == commit_e[k]) model_commit(k);
                    if (pend[k] && edge_n == due_e[k]) begin
                        rv_e[k] = 1'b1; pend[k] = 1'b0;
                    end else begin
                        rv_e[k] = 1'b0;
                    end
                    if (rb && req_valid[k] === 1'b1) begin
                        pend[k]     = 1'b1;
                        p_wr[k]     = req_write[k];
                        p_addr[k]   = req_addr[k];
                        p_wdata[k]  = req_wdata[k];
                        commit_e[k] = edge_n + wait_of(k);
                        due_e[k]    = commit_e[k] + 1;
                        if (commit_e[k] == edge_n) model_commit(k);
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------- compare
    initial begin
        forever begin
            @(negedge clock);
            for (int k = 0; k < c_n; k++) begin
                if (!reset_l) begin
                    chk("rst_req_ready",  k, {31'd0, req_ready[k]},  32'd1);
                    chk("rst_resp_valid", k, {31'd0, resp_valid[k]}, 32'd0);
                    chk("rst_resp_rdata", k, resp_rdata[k],          32'd0);
                    chk("rst_resp_err",   k, {31'd0, resp_err[k]},   32'd0);
                end else begin
                    chk("req_ready",  k, {31'd0, req_ready[k]},  {31'd0, !pend[k]});
                    chk("resp_valid", k, {31'd0, resp_valid[k]}, {31'd0, rv_e[k]});
                    chk("resp_err",   k, {31'd0, resp_err[k]},   {31'd0, cur_err[k]});
                    if (cur_known[k]) chk("resp_rdata", k, resp_rdata[k], cur_rd[k]);
                end
            end
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic do_req(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clock);
        req_write[k] = w; req_addr[k] = a; req_wdata[k] = d; req_valid[k] = 1'b1;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("ready_timeout", k, {31'd0, req_ready[k]}, 32'd1);
        @(posedge clock);
        #1;
        req_valid[k] = 1'b0; req_write[k] = 1'($urandom_range(0, 1));
        req_addr[k] = $urandom; req_wdata[k] = $urandom;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (resp_valid[k] !== 1'b1 && lat < 40);
        chk("resp_timeout", k, {31'd0, resp_valid[k]}, 32'd1);
        rd = resp_rdata[k];
        er = resp_err[k];
    endtask

    function automatic logic [31:0] rand_addr();
        int          sel;
        logic [31:0] a;
        sel = $urandom_range(0, 9);
        a   = 32'($urandom_range(0, 15)) << 2;
        case (sel)
            7:       a = a | 32'($urandom_range(1, 3));
            8:       a = 32'h400 | a;
            9:       a = ($urandom_range(0, 1) == 1) ? 32'h3FC : 32'h8000_0010;
            default: a = a;
        endcase
        return a;
    endfunction

    task automatic rand_phase(input int k, input int ncyc, input int vprob);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock);
            req_valid[k] = ($urandom_range(0, 99) < vprob);
            req_write[k] = 1'($urandom_range(0, 1));
            req_addr[k]  = rand_addr();
            req_wdata[k] = $urandom;
        end
        @(negedge clock);
        req_valid[k] = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          seen;
        for (int k = 0; k < c_n; k++) begin
            req_valid[k] = 1'b0; req_write[k] = 1'b0;
            req_addr[k]  = 32'd0; req_wdata[k] = 32'd0;
        end
        repeat (3) @(negedge clock);
        reset_l = 1'b1;
        @(negedge clock);
        for (int k = 0; k < c_n; k++) begin
            chk("idle_ready", k, {31'd0, req_ready[k]},  32'd1);
            chk("idle_valid", k, {31'd0, resp_valid[k]}, 32'd0);
            chk("idle_rdata", k, resp_rdata[k],          32'd0);
            chk("idle_err",   k, {31'd0, resp_err[k]},   32'd0);
        end

        // One wait state: response two edges after accept.
        do_req(1, 1'b1, 32'h010, 32'hDEADBEEF, rd, er, lat);
        chk("w1_wr_lat", 1, 32'(lat), 32'd3);
        chk("w1_wr_err", 1, {31'd0, er}, 32'd0);
        chk("w1_wr_rd",  1, rd, 32'd0);
        do_req(1, 1'b0, 32'h010, 32'd0, rd, er, lat);
        chk("w1_rd_data", 1, rd, 32'hDEADBEEF);

        // Zero wait states, both ends of the array.
        do_req(0, 1'b1, 32'h000, 32'h11111111, rd, er, lat);
        chk("w0_lat", 0, 32'(lat), 32'd2);
        do_req(0, 1'b1, 32'h3FC, 32'h22222222, rd, er, lat);
        do_req(0, 1'b0, 32'h000, 32'd0, rd, er, lat);
        chk("w0_rd_lo", 0, rd, 32'h11111111);
        do_req(0, 1'b0, 32'h3FC, 32'd0, rd, er, lat);
        chk("w0_rd_hi", 0, rd, 32'h22222222);

        // Out of range accesses.
        do_req(0, 1'b0, 32'h400, 32'd0, rd, er, lat);
        chk("oor_rd_err", 0, {31'd0, er}, 32'd1);
        chk("oor_rd_rd",  0, rd, 32'd0);
        do_req(0, 1'b1, 32'h400, 32'h55, rd, er, lat);
        chk("oor_wr_err", 0, {31'd0, er}, 32'd1);
        chk("oor_wr_rd",  0, rd, 32'd0);
        do_req(0, 1'b0, 32'h000, 32'd0, rd, er, lat);
        chk("oor_no_alias", 0, rd, 32'h11111111);

        // Reset during the wait states abandons the write.
        do_req(2, 1'b1, 32'h020, 32'h12345678, rd, er, lat);
        chk("w3_lat", 2, 32'(lat), 32'd5);
        @(negedge clock);
        req_write[2] = 1'b1; req_addr[2] = 32'h020; req_wdata[2] = 32'hCAFEF00D; req_valid[2] = 1'b1;
        @(posedge clock);
        #1 req_valid[2] = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2 reset_l = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_l = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (resp_valid[2] === 1'b1) seen++;
        end
        chk("rst_no_resp", 2, 32'(seen), 32'd0);
        chk("rst_ready",   2, {31'd0, req_ready[2]}, 32'd1);
        do_req(2, 1'b0, 32'h020, 32'd0, rd, er, lat);
        chk("rst_old_val", 2, rd, 32'h12345678);
        do_req(2, 1'b1, 32'h020, 32'h0, rd, er, lat);
        do_req(2, 1'b0, 32'h020, 32'd0, rd, er, lat);
        chk("rst_new_val", 2, rd, 32'h0);

        // Misaligned read.
        do_req(1, 1'b0, 32'h012, 32'd0, rd, er, lat);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        chk("align_err", 1, {31'd0, er}, 32'd1);
        chk("align_rd",  1, rd, 32'd0);
`else
        chk("align_err", 1, {31'd0, er}, 32'd0);
        chk("align_rd",  1, rd, 32'hDEADBEEF);
`endif

        // Randomized traffic, including a saturated stream with no wait states.
        rand_phase(0, 200, 100);
        rand_phase(0, 150, 50);
        rand_phase(1, 200, 60);
        rand_phase(2, 200, 60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Word-addressed memory responder for the multicycle datapath's memory bus. It accepts one read or write request at a time through a valid/ready handshake, inserts a configurable number of wait states, and returns a one-cycle response pulse carrying read data and an error flag. It replaces the zero-latency memory model, so the datapath and control unit can be exercised against a slow, stalling memory.

Parameters:
ADDR_BITS, 8, log2 of storage depth in 32-bit words (256 words, byte range 0x000-0x3FF)
WAIT_CYCLES, 1, wait states between accept and response (0-15)

Ports:
clock  input  1  system clock, rising edge
reset_l  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_write  input  1  1 = write, 0 = read
req_addr  input  32  byte address
req_wdata  input  32  write data
req_ready  output  1  responder can accept a request
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  read data; valid while resp_valid=1
resp_err  output  1  access rejected; valid while resp_valid=1

Behaviour:
- One clock. Reset is asynchronous and active-low; the ports are named clock and reset_l.
- Reset values:
  - state IDLE, wait counter 0, resp_valid 0, resp_rdata 0, resp_err 0.
  - req_ready is decoded combinationally as state==IDLE, so it reads 1 during and after reset.
  - Storage array is not reset; its contents are undefined until written.
- FSM states IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On an edge with req_valid=1, the request is accepted and req_write, req_addr and req_wdata are latched. Next state is WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise RESP.
  - WAIT: req_ready=0. The counter decrements each edge; at counter==0 the next state is RESP.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle, then IDLE.
- Latency: the accept edge is edge N. resp_valid is high during the cycle following edge N+WAIT_CYCLES+1. The next accept is possible at edge N+WAIT_CYCLES+2 at the earliest.
- Request inputs are ignored outside IDLE. Only the values latched at the accept edge are used.
- There is no response backpressure; the initiator must sample on resp_valid.
- Address decode:
  - word index = latched addr[ADDR_BITS+1:2].
  - In range: addr[31:ADDR_BITS+2]==0.
- Commit edge: the edge that enters RESP is the only edge that commits a write or samples the array for a read.
  - Read in range: resp_rdata = mem[index], resp_err=0.
  - Write in range: mem[index] <= wdata, resp_err=0, resp_rdata = 0.
  - Out of range: the array is untouched, resp_rdata=0, resp_err=1.
- resp_rdata and resp_err hold their values after RESP until the next commit edge.
- Read-after-write to the same word returns the newly written value.
- Reset asserted mid-operation: the pending access is abandoned immediately. A write not yet committed is never performed, and no response is issued.
- Address bits [1:0] are ignored unless the optional feature is enabled.

Optional Feature:
Macro MEM_RESPONDER_ALIGN_CHECK_EN.
- Defined: a latched addr[1:0]!=0 is treated as an error, identical to out of range: the array is untouched, resp_rdata=0, resp_err=1. Latency is unchanged.
- Undefined: addr[1:0] is ignored and the access goes to word addr[ADDR_BITS+1:2].

Test Plan:
- Reset, then idle with req_valid=0 -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- WAIT_CYCLES=1: write 0xDEADBEEF to 0x010 accepted at edge N, then read 0x010 -> write resp_valid in the cycle after edge N+2, resp_err=0; read returns 0xDEADBEEF. req_ready is 0 between accept and response.
- WAIT_CYCLES=0: back-to-back writes 0x11111111@0x000 and 0x22222222@0x3FC, then read both -> one response every 2 cycles, returning 0x11111111 and 0x22222222.
- Read 0x400, then write 0x55 to 0x400 -> both respond with resp_err=1 and resp_rdata=0. A subsequent read of 0x000 returns the unchanged prior value.
- Write 0xCAFEF00D to 0x020 accepted with WAIT_CYCLES=3; pulse reset_l low during WAIT -> no resp_valid, req_ready=1 afterwards. After writing 0x0 to 0x020 and reading it back, the result is 0x0, never 0xCAFEF00D.
- Read 0x012 -> with MEM_RESPONDER_ALIGN_CHECK_EN: resp_err=1, resp_rdata=0. Without it: resp_err=0, data of word 0x010.
